lfsr_rng_sampler: RTL
=====================

// Module: lfsr_rng_sampler
// PURPOSE
//  Parametrised Fibonacci LFSR random-number source. Shifts once per enabled cycle
//  and captures a WIDTH-bit sample every SHIFTS shifts into an output register.
//  The sample is offered on a valid/ready handshake.
//  Feeds game logic and the hex_display digit drivers (low 4 bits) with fresh values.
// PARAMETERS
//  WIDTH   13        LFSR/sample width in bits (>=3)
//  TAPS    13'h100D  feedback mask; bit i=1 -> state[i] XORed into feedback
//  SEED    13'h000F  reset/fallback state; must be non-zero
//  SHIFTS  13        shifts per captured sample (>=1); counter width = max(1,$clog2(SHIFTS))
// PORTS
//  clock         in   1      rising-edge clock
//  reset         in   1      asynchronous, active-high reset
//  enable        in   1      1 = advance LFSR one shift this cycle
//  seed_load     in   1      1 = load seed_in into LFSR this cycle
//  seed_in       in   WIDTH  seed value
//  sample_valid  out  1      sample holds an unconsumed value
//  sample_ready  in   1      consumer accepts sample when sample_valid=1
//  sample        out  WIDTH  captured LFSR state
//  overrun       out  1      1-cycle pulse: an unconsumed sample was overwritten
// BEHAVIOUR
//  - Reset (async, high): state=SEED, cnt=0, sample=0, sample_valid=0, overrun=0.
//  - Feedback fb = ^(state & TAPS). Shift: state <= {state[WIDTH-2:0], fb}.
//  - Priority per cycle: seed_load > enable > hold.
//  - seed_load: state <= (seed_in==0) ? SEED : seed_in; cnt <= 0.
//    No shift and no capture that cycle. sample and sample_valid are untouched.
//  - enable (no seed_load): shift once.
//    - If cnt==SHIFTS-1: cnt<=0 and capture; sample <= post-shift state; sample_valid <= 1.
//    - Else cnt<=cnt+1.
//  - enable=0 (no seed_load): state and cnt hold.
//  - Latency: the first sample is valid the cycle after the SHIFTS-th enabled edge.
//  - Handshake: transfer occurs on an edge with sample_valid&sample_ready.
//    sample_valid then drops unless a capture happens on the same edge.
//    With a same-edge capture, valid stays 1 and sample = new value; no overrun.
//  - Capture while sample_valid=1 and sample_ready=0 overwrites sample.
//    overrun=1 for exactly the following cycle; sample_valid stays 1.
//  - sample is stable while sample_valid=1 and no capture occurs.
//  - The all-zero state is unreachable: reset and seed paths substitute SEED for zero.
//  - State never wraps into zero; the sequence period is set by TAPS (maximal for default).
// CONFIGURATION
//  RNG_OVERRUN_CNT_EN defined:
//    - Adds output port overrun_count (8 bits), reset 0.
//    - Increments on each overrun event, saturating at 8'hFF.
//    - Cleared by seed_load.
//  RNG_OVERRUN_CNT_EN undefined:
//    - Port absent; no counter logic.
//    - The overrun pulse is still generated.
// TESTING
//  T1 reset, enable=1 for 13 cycles, ready=0
//     -> states 0x001F,0x003F..0x1FFF,0x1FFE,0x1FFD,0x1FFA,0x1FF4; sample=0x1FF4, valid=1.
//  T2 seed_load=1, seed_in=0
//     -> state=0x000F, cnt=0. Then seed_in=0x0001 load + 1 enable -> state=0x0003.
//  T3 ready=0, enable held 26 cycles
//     -> 2nd capture: overrun pulses 1 cycle, valid=1, sample = model state after 26 shifts.
//  T4 ready=1 on the same edge as a capture
//     -> valid stays 1, new sample shown, overrun=0. With ready=1 and no capture, valid->0 next cycle.
//  T5 assert reset mid-sample (cnt=7, valid=1)
//     -> immediately state=0x000F, valid=0, sample=0, overrun=0. Next sample again 0x1FF4.
//  T6 RNG_OVERRUN_CNT_EN defined, force 300 overruns
//     -> overrun_count=8'hFF. Then seed_load -> 0.

Source files
------------

// File: rtl/lfsr_rng_sampler.sv
// Fibonacci LFSR random source that captures a sample every SHIFTS shifts and offers it on valid/ready.
// Define RNG_OVERRUN_CNT_EN to add the saturating overrun_count output.
module lfsr_rng_sampler #(
  parameter int                WIDTH  = 13,
  parameter logic [WIDTH-1:0]  TAPS   = 13'h100D,
  parameter logic [WIDTH-1:0]  SEED   = 13'h000F,
  parameter int                SHIFTS = 13
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              seed_load,
  input  logic [WIDTH-1:0]  seed_in,
  output logic              sample_valid,
  input  logic              sample_ready,
  output logic [WIDTH-1:0]  sample,
  output logic              overrun
`ifdef RNG_OVERRUN_CNT_EN
  ,
  output logic [7:0]        overrun_count
`endif
);

  localparam int              CNT_W    = (SHIFTS > 1) ? $clog2(SHIFTS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SHIFTS - 1);

  function automatic logic feedback(input logic [WIDTH-1:0] s);
    return ^(s & TAPS);
  endfunction

  function automatic logic [WIDTH-1:0] shift_next(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], feedback(s)};
  endfunction

  // Zero would lock the LFSR, so any zero seed falls back to SEED.
  function automatic logic [WIDTH-1:0] seed_sanitize(input logic [WIDTH-1:0] v);
    return (v == '0) ? SEED : v;
  endfunction

  logic [WIDTH-1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] state_shift;
  logic             advance;
  logic             capture;
  logic             transfer;
  logic             overrun_event;

  always_comb begin
    state_shift   = shift_next(state);
    advance       = enable && !seed_load;
    capture       = advance && (cnt == CNT_LAST);
    transfer      = sample_valid && sample_ready;
    overrun_event = capture && sample_valid && !sample_ready;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= SEED;
      cnt   <= '0;
    end else if (seed_load) begin
      state <= seed_sanitize(seed_in);
      cnt   <= '0;
    end else if (enable) begin
      state <= state_shift;
      cnt   <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  // A capture wins over a same-edge transfer: the new value stays valid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= overrun_event;
      if (capture) begin
        sample       <= state_shift;
        sample_valid <= 1'b1;
      end else if (transfer) begin
        sample_valid <= 1'b0;
      end
    end
  end

`ifdef RNG_OVERRUN_CNT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overrun_count <= 8'h00;
    end else if (seed_load) begin
      overrun_count <= 8'h00;
    end else if (overrun_event && (overrun_count != 8'hFF)) begin
      overrun_count <= overrun_count + 8'h01;
    end
  end
`endif

endmodule
